// File: rtl/alu_core_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_core_seq
// Purpose  : Execution-side ALU driven by the 4-bit ALUcontrol code. Accepts
//            one operation per valid/ready handshake, computes the result,
//            zero flag and branch condition, and holds them until the
//            downstream stage accepts. SLL is iterative (one bit per cycle)
//            unless the barrel-shift build option is enabled.
// Options  : ALU_CORE_BARREL_SHIFT_EN - when defined, SLL is a single-cycle
//            barrel shift and the SHIFT state is never entered.
// Ports    : clk          - system clock, rising edge
//            reset        - synchronous, active-high reset
//            in_valid     - operation request valid
//            in_ready     - block can accept an operation this cycle
//            alu_ctrl     - ALUcontrol code from the decoder
//            op_a, op_b   - operands (rs1, rs2/immediate)
//            out_valid    - result valid, held until accepted
//            out_ready    - downstream accepts the result
//            result       - ALU result
//            zero         - result == 0
//            branch_cond  - branch-taken condition (zero for non-branch codes)
// Revision : 1.0 - initial release
// ============================================================================
module alu_core_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             branch_cond
);

  localparam int         c_SHAMT_W = 5;
  localparam logic [3:0] c_OP_AND  = 4'b0000;
  localparam logic [3:0] c_OP_OR   = 4'b0001;
  localparam logic [3:0] c_OP_ADD  = 4'b0010;
  localparam logic [3:0] c_OP_BEQ  = 4'b0110;
  localparam logic [3:0] c_OP_BNE  = 4'b0011;
  localparam logic [3:0] c_OP_BLT  = 4'b1000;
  localparam logic [3:0] c_OP_SLT  = 4'b0111;
  localparam logic [3:0] c_OP_XOR  = 4'b1001;
  localparam logic [3:0] c_OP_SLL  = 4'b0100;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;

  logic [WIDTH-1:0]       r_result;
  logic                   r_zero;
  logic                   r_branch;

  logic [c_SHAMT_W-1:0]   w_shamt;
  logic [WIDTH-1:0]       w_sum;
  logic [WIDTH-1:0]       w_diff;
  logic                   w_lt;
  logic [WIDTH-1:0]       w_res;
  logic                   w_is_branch;
  logic                   w_branch_val;
  logic                   w_zero;
  logic                   w_branch;
  logic                   w_start_shift;
  logic                   w_load_result;
  logic                   w_load_shift;
  logic                   w_shift_last;

  assign w_shamt = op_b[c_SHAMT_W-1:0];
  assign w_sum   = op_a + op_b;
  assign w_diff  = op_a - op_b;
  assign w_lt    = ($signed(op_a) < $signed(op_b));

  // Single-cycle result for the operation currently on the inputs.
  always_comb begin : p_compute
    w_res        = w_sum;
    w_is_branch  = 1'b0;
    w_branch_val = 1'b0;
    case (alu_ctrl)
      c_OP_AND: w_res = op_a & op_b;
      c_OP_OR:  w_res = op_a | op_b;
      c_OP_ADD: w_res = w_sum;
      c_OP_BEQ: begin
        w_res        = w_diff;
        w_is_branch  = 1'b1;
        w_branch_val = (op_a == op_b);
      end
      c_OP_BNE: begin
        w_res        = w_diff;
        w_is_branch  = 1'b1;
        w_branch_val = (op_a != op_b);
      end
      c_OP_BLT: begin
        w_res        = {{(WIDTH-1){1'b0}}, w_lt};
        w_is_branch  = 1'b1;
        w_branch_val = w_lt;
      end
      c_OP_SLT: begin
        w_res        = {{(WIDTH-1){1'b0}}, w_lt};
        w_is_branch  = 1'b1;
        w_branch_val = ~w_lt;
      end
      c_OP_XOR: w_res = op_a ^ op_b;
`ifdef ALU_CORE_BARREL_SHIFT_EN
      c_OP_SLL: w_res = op_a << w_shamt;
`else
      // Only reached with shamt == 0 here; nonzero shifts go through SHIFT.
      c_OP_SLL: w_res = op_a;
`endif
      default:  w_res = w_sum;
    endcase
  end

  assign w_zero   = (w_res == '0);
  assign w_branch = w_is_branch ? w_branch_val : w_zero;

`ifdef ALU_CORE_BARREL_SHIFT_EN
  assign w_start_shift = 1'b0;
`else
  assign w_start_shift = (alu_ctrl == c_OP_SLL) && (w_shamt != '0);

  logic [WIDTH-1:0]     r_shreg;
  logic [c_SHAMT_W-1:0] r_cnt;
  logic [WIDTH-1:0]     w_sh_res;

  // Value of the shift register after the shift happening this cycle.
  assign w_sh_res = {r_shreg[WIDTH-2:0], 1'b0};

  always_ff @(posedge clk) begin : p_shift
    if (reset) begin
      r_shreg <= '0;
      r_cnt   <= '0;
    end else if (w_load_shift) begin
      r_shreg <= op_a;
      r_cnt   <= w_shamt;
    end else if (r_state == S_SHIFT) begin
      r_shreg <= w_sh_res;
      r_cnt   <= r_cnt - 5'd1;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk) begin : p_state
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin : p_fsm
    w_state_nxt   = r_state;
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    w_load_result = 1'b0;
    w_load_shift  = 1'b0;
    w_shift_last  = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (w_start_shift) begin
            w_load_shift = 1'b1;
            w_state_nxt  = S_SHIFT;
          end else begin
            w_load_result = 1'b1;
            w_state_nxt   = S_DONE;
          end
        end
      end
      S_SHIFT: begin
`ifdef ALU_CORE_BARREL_SHIFT_EN
        w_state_nxt = S_IDLE;
`else
        if (r_cnt == 5'd1) begin
          w_shift_last = 1'b1;
          w_state_nxt  = S_DONE;
        end
`endif
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          // Result leaves this cycle, so a new op may enter in the same cycle.
          in_ready = 1'b1;
          if (in_valid) begin
            if (w_start_shift) begin
              w_load_shift = 1'b1;
              w_state_nxt  = S_SHIFT;
            end else begin
              w_load_result = 1'b1;
              w_state_nxt   = S_DONE;
            end
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Result, zero and branch condition are always registered together.
  always_ff @(posedge clk) begin : p_result
    if (reset) begin
      r_result <= '0;
      r_zero   <= 1'b1;
      r_branch <= 1'b0;
    end else if (w_load_result) begin
      r_result <= w_res;
      r_zero   <= w_zero;
      r_branch <= w_branch;
    end
`ifndef ALU_CORE_BARREL_SHIFT_EN
    else if (w_shift_last) begin
      // SLL is not a branch code, so branch_cond follows zero.
      r_result <= w_sh_res;
      r_zero   <= (w_sh_res == '0);
      r_branch <= (w_sh_res == '0);
    end
`endif
  end

  assign result      = r_result;
  assign zero        = r_zero;
  assign branch_cond = r_branch;

endmodule
`default_nettype wire

// File: tb/tb_alu_core_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_core_seq
// Purpose  : Directed self-checking bench for alu_core_seq.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_core_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        branch_cond;

  int n_chk = 0;
  int n_err = 0;

  alu_core_seq #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_ctrl   (alu_ctrl),
    .op_a       (op_a),
    .op_b       (op_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .branch_cond(branch_cond)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Present one op for a single edge (caller guarantees in_ready).
  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    alu_ctrl = c; op_a = a; op_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic go_idle();
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    n_chk++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
    n_chk++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    n_chk++; if (result !== 32'h0) begin n_err++; $display("FAIL rst_result got %h exp 0", result); end
    n_chk++; if (zero !== 1'b1) begin n_err++; $display("FAIL rst_zero got %b exp 1", zero); end
    n_chk++; if (branch_cond !== 1'b0) begin n_err++; $display("FAIL rst_branch got %b exp 0", branch_cond); end
  endtask

  task automatic test_add_sub();
    out_ready = 1'b1;
    issue(4'b0010, 32'h7FFF_FFFF, 32'h1);
    n_chk++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL add_valid got %b exp 1", out_valid); end
    n_chk++; if (result !== 32'h8000_0000) begin n_err++; $display("FAIL add_result got %h exp 80000000", result); end
    n_chk++; if (zero !== 1'b0) begin n_err++; $display("FAIL add_zero got %b exp 0", zero); end
    n_chk++; if (branch_cond !== 1'b0) begin n_err++; $display("FAIL add_branch got %b exp 0", branch_cond); end
    issue(4'b0110, 32'd5, 32'd5);
    n_chk++; if (result !== 32'h0) begin n_err++; $display("FAIL sub_result got %h exp 0", result); end
    n_chk++; if (zero !== 1'b1) begin n_err++; $display("FAIL sub_zero got %b exp 1", zero); end
    n_chk++; if (branch_cond !== 1'b1) begin n_err++; $display("FAIL beq_taken got %b exp 1", branch_cond); end
  endtask

  task automatic test_branch();
    issue(4'b1000, 32'hFFFF_FFFE, 32'd3);
    n_chk++; if (result !== 32'h1) begin n_err++; $display("FAIL blt_result got %h exp 1", result); end
    n_chk++; if (branch_cond !== 1'b1) begin n_err++; $display("FAIL blt_branch got %b exp 1", branch_cond); end
    issue(4'b0111, 32'hFFFF_FFFE, 32'd3);
    n_chk++; if (result !== 32'h1) begin n_err++; $display("FAIL slt_result got %h exp 1", result); end
    n_chk++; if (branch_cond !== 1'b0) begin n_err++; $display("FAIL bge_branch got %b exp 0", branch_cond); end
    issue(4'b0011, 32'hFFFF_FFFE, 32'd3);
    n_chk++; if (result !== 32'hFFFF_FFFB) begin n_err++; $display("FAIL bne_result got %h exp fffffffb", result); end
    n_chk++; if (branch_cond !== 1'b1) begin n_err++; $display("FAIL bne_branch got %b exp 1", branch_cond); end
    issue(4'b0110, 32'hFFFF_FFFE, 32'd3);
    n_chk++; if (branch_cond !== 1'b0) begin n_err++; $display("FAIL beq_not_taken got %b exp 0", branch_cond); end
    issue(4'b0111, 32'd3, 32'hFFFF_FFFE);
    n_chk++; if (result !== 32'h0 || branch_cond !== 1'b1) begin
      n_err++; $display("FAIL bge_taken got r=%h b=%b exp r=0 b=1", result, branch_cond);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    issue(4'b0000, 32'hFF00_FF00, 32'h0FF0_0FF0);
    n_chk++; if (result !== 32'h0F00_0F00 || out_valid !== 1'b1) begin
      n_err++; $display("FAIL b2b_and got %h v=%b exp 0f000f00 v=1", result, out_valid);
    end
    issue(4'b0001, 32'hFF00_FF00, 32'h0FF0_0FF0);
    n_chk++; if (result !== 32'hFFF0_FFF0 || out_valid !== 1'b1) begin
      n_err++; $display("FAIL b2b_or got %h v=%b exp fff0fff0 v=1", result, out_valid);
    end
    issue(4'b1001, 32'hFF00_FF00, 32'h0FF0_0FF0);
    n_chk++; if (result !== 32'hF0F0_F0F0 || out_valid !== 1'b1) begin
      n_err++; $display("FAIL b2b_xor got %h v=%b exp f0f0f0f0 v=1", result, out_valid);
    end
    go_idle();
    n_chk++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_sll();
    int lat;
    int low;
    int exp_lat;
    out_ready = 1'b1;
    // shamt 5: five cycles with in_ready low, then the result
    issue(4'b0100, 32'h1, 32'h25);
    lat = 0; low = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      if (in_ready === 1'b0) low++;
      @(posedge clk); #1; lat++;
    end
`ifdef ALU_CORE_BARREL_SHIFT_EN
    exp_lat = 0;
`else
    exp_lat = 5;
`endif
    n_chk++; if (lat !== exp_lat) begin n_err++; $display("FAIL sll5_latency got %0d exp %0d", lat, exp_lat); end
    n_chk++; if (low !== exp_lat) begin n_err++; $display("FAIL sll5_busy got %0d exp %0d", low, exp_lat); end
    n_chk++; if (result !== 32'h20) begin n_err++; $display("FAIL sll5_result got %h exp 20", result); end
    go_idle();
    // shamt 0 (upper bits of b ignored): single-cycle
    issue(4'b0100, 32'h1, 32'h20);
    n_chk++; if (out_valid !== 1'b1 || result !== 32'h1) begin
      n_err++; $display("FAIL sll0 got v=%b r=%h exp v=1 r=1", out_valid, result);
    end
    go_idle();
    // shamt 1: MSB shifted out
    issue(4'b0100, 32'h8000_0001, 32'h1);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
`ifdef ALU_CORE_BARREL_SHIFT_EN
    exp_lat = 0;
`else
    exp_lat = 1;
`endif
    n_chk++; if (lat !== exp_lat) begin n_err++; $display("FAIL sll1_latency got %0d exp %0d", lat, exp_lat); end
    n_chk++; if (result !== 32'h2 || zero !== 1'b0) begin
      n_err++; $display("FAIL sll1_result got %h z=%b exp 2 z=0", result, zero);
    end
    go_idle();
  endtask

  task automatic test_backpressure();
    go_idle();
    out_ready = 1'b0;
    issue(4'b1001, 32'h0000_F0F0, 32'h0000_FFFF);
    // A competing request is offered the whole time; it must not be taken.
    alu_ctrl = 4'b0010; op_a = 32'd10; op_b = 32'd20; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (out_valid !== 1'b1 || result !== 32'h0F0F || in_ready !== 1'b0) begin
        n_err++; $display("FAIL bp_hold%0d got v=%b r=%h rdy=%b exp v=1 r=00000f0f rdy=0", i, out_valid, result, in_ready);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    n_chk++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready got %b exp 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_chk++; if (out_valid !== 1'b1 || result !== 32'd30) begin
      n_err++; $display("FAIL bp_new_op got v=%b r=%h exp v=1 r=1e", out_valid, result);
    end
    go_idle();
  endtask

  task automatic test_reset_mid_op();
    int pulses;
    out_ready = 1'b1;
    issue(4'b0100, 32'h1, 32'd20);
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_shift_busy got %b exp 0", in_ready); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_chk++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL rst_shift_idle got rdy=%b v=%b exp rdy=1 v=0", in_ready, out_valid);
    end
    n_chk++; if (result !== 32'h0 || zero !== 1'b1) begin
      n_err++; $display("FAIL rst_shift_result got %h z=%b exp 0 z=1", result, zero);
    end
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) pulses++;
    end
    n_chk++; if (pulses !== 0) begin n_err++; $display("FAIL rst_shift_no_pulse got %0d exp 0", pulses); end
    // Reset while holding a result in DONE
    out_ready = 1'b0;
    issue(4'b0010, 32'd1, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_chk++; if (out_valid !== 1'b0 || result !== 32'h0) begin
      n_err++; $display("FAIL rst_done got v=%b r=%h exp v=0 r=0", out_valid, result);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_default_code();
    go_idle();
    issue(4'b1111, 32'd2, 32'd3);
    n_chk++; if (result !== 32'd5 || branch_cond !== 1'b0) begin
      n_err++; $display("FAIL code1111 got r=%h b=%b exp r=5 b=0", result, branch_cond);
    end
    issue(4'b1010, 32'd7, 32'd8);
    n_chk++; if (result !== 32'd15) begin n_err++; $display("FAIL code1010 got %h exp f", result); end
    issue(4'b0010, 32'hFFFF_FFFF, 32'd1);
    n_chk++; if (result !== 32'h0 || zero !== 1'b1 || branch_cond !== 1'b1) begin
      n_err++; $display("FAIL add_wrap got r=%h z=%b b=%b exp r=0 z=1 b=1", result, zero, branch_cond);
    end
    go_idle();
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    alu_ctrl = 4'b0; op_a = '0; op_b = '0;
    test_reset();
    test_add_sub();
    test_branch();
    test_back_to_back();
    test_sll();
    test_backpressure();
    test_reset_mid_op();
    test_default_code();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
